// File: rtl/lfsr_pkg.sv
// Shared constants and FSM encoding for the LFSR keystream generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_pkg;

    // Fallback state, used after reset, after a zero seed and after a lock-up trap
    localparam logic [127:0] LFSR_DEFAULT_SEED = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;

    // x^128 + x^30 + x^28 + x^3 style tap set on the 128-bit register
    localparam logic [127:0] LFSR_DEFAULT_TAP_MASK = (128'd1 << 127) | (128'd1 << 29)
                                                   | (128'd1 << 27)  | (128'd1 << 2);

    // WARMUP discards output bits, RUN packs them into keystream words
    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } ks_state_e;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with feedback XOR and all-zero lock-up guard.
// Latency: state and lockup update on the clock edge after step/load.
// Backpressure: none; the register only moves when step or load is asserted.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 128,
    parameter logic [WIDTH-1:0] TAP_MASK     = WIDTH'(LFSR_DEFAULT_TAP_MASK),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             lockup
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] shifted;
    logic             fb;
    logic             lockup_q;
    logic             lockup_d;

    // Next state: load wins over step; a zero seed or a zero successor falls back to DEFAULT_SEED
    always_comb begin
        fb       = ^(state_q & TAP_MASK);
        shifted  = {fb, state_q[WIDTH-1:1]};
        state_d  = state_q;
        lockup_d = 1'b0;
        if (load) begin
            state_d = (load_val == '0) ? DEFAULT_SEED : load_val;
        end else if (step) begin
            if (shifted == '0) begin
                state_d  = DEFAULT_SEED;
                lockup_d = 1'b1;
            end else begin
                state_d  = shifted;
            end
        end
    end

    // State register and single-cycle lock-up pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DEFAULT_SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    assign state   = state_q;
    assign out_bit = state_q[0];
    assign lockup  = lockup_q;

endmodule

// File: rtl/lfsr_keystream.sv
// LFSR keystream generator: warm-up discard, then packs serial bits into KS_W-bit words.
// Latency: first word valid the cycle after the KS_W-th RUN step; then one word per KS_W cycles.
// Backpressure: two-entry buffer (accumulator + output register); stepping stalls when both are full.
module lfsr_keystream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 128,
    parameter logic [WIDTH-1:0] TAP_MASK     = WIDTH'(LFSR_DEFAULT_TAP_MASK),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED),
    parameter int               KS_W         = 8,
    parameter int               WARMUP_STEPS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [KS_W-1:0]  ks_data,
    output logic             busy,
    output logic             zero_seed_err,
    output logic             lockup,
    output logic [WIDTH-1:0] state_out
);

    localparam int WC_W = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;
    localparam int BC_W = (KS_W > 1) ? $clog2(KS_W) : 1;
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP_STEPS);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(KS_W - 1);
    // With no warm-up configured the generator starts straight in RUN
    localparam ks_state_e ST_START = (WARMUP_STEPS > 0) ? ST_WARMUP : ST_RUN;

    ks_state_e        fsm_q, fsm_d;
    logic [WC_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [KS_W-1:0]  acc_q, acc_d;
    logic             acc_full_q, acc_full_d;
    logic             ks_valid_q, ks_valid_d;
    logic [KS_W-1:0]  ks_data_q, ks_data_d;
    logic             zero_seed_err_q, zero_seed_err_d;
    logic [KS_W-1:0]  word;
    logic             handshake;
    logic             core_step;
    logic             core_bit;
    logic [WIDTH-1:0] core_state;

    assign handshake = ks_valid_q & ks_ready;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAP_MASK     (TAP_MASK),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (core_step),
        .load     (seed_load),
        .load_val (seed),
        .state    (core_state),
        .out_bit  (core_bit),
        .lockup   (lockup)
    );

    // Control: reseed flush, warm-up counting, bit packing and the acc -> output transfer
    always_comb begin
        fsm_d           = fsm_q;
        warm_cnt_d      = warm_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        acc_d           = acc_q;
        acc_full_d      = acc_full_q;
        ks_valid_d      = ks_valid_q;
        ks_data_d       = ks_data_q;
        zero_seed_err_d = zero_seed_err_q;
        core_step       = 1'b0;
        word            = acc_q;

        if (seed_load) begin
            // Reseed drops everything buffered, including a word handed over this cycle
            zero_seed_err_d = (seed == '0);
            fsm_d           = ST_START;
            warm_cnt_d      = '0;
            bit_cnt_d       = '0;
            acc_full_d      = 1'b0;
            ks_valid_d      = 1'b0;
        end else begin
            if (handshake) begin
                if (acc_full_q) begin
                    ks_data_d  = acc_q;
                    acc_full_d = 1'b0;
                end else begin
                    ks_valid_d = 1'b0;
                end
            end

            if (fsm_q == ST_WARMUP) begin
                if (enable) begin
                    core_step  = 1'b1;
                    warm_cnt_d = warm_cnt_q + 1'b1;
                    if (warm_cnt_d == WARM_LAST) begin
                        fsm_d = ST_RUN;
                    end
                end
            end else if (enable && !acc_full_q) begin
                core_step       = 1'b1;
                word[bit_cnt_q] = core_bit;
                acc_d           = word;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    // Output register free (or emptying now): move the word straight out
                    if (!ks_valid_q || handshake) begin
                        ks_data_d  = word;
                        ks_valid_d = 1'b1;
                    end else begin
                        acc_full_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q           <= ST_START;
            warm_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            acc_q           <= '0;
            acc_full_q      <= 1'b0;
            ks_valid_q      <= 1'b0;
            ks_data_q       <= '0;
            zero_seed_err_q <= 1'b0;
        end else begin
            fsm_q           <= fsm_d;
            warm_cnt_q      <= warm_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            acc_q           <= acc_d;
            acc_full_q      <= acc_full_d;
            ks_valid_q      <= ks_valid_d;
            ks_data_q       <= ks_data_d;
            zero_seed_err_q <= zero_seed_err_d;
        end
    end

    assign ks_valid      = ks_valid_q;
    assign ks_data       = ks_data_q;
    assign busy          = (fsm_q == ST_WARMUP);
    assign zero_seed_err = zero_seed_err_q;
    assign state_out     = core_state;

endmodule

// File: tb/tb_lfsr_keystream.sv
// Directed + randomized bench for lfsr_keystream against a bit-serial reference model.
// Latency: checks first-word timing, warm-up length and steady one-word-per-8-cycle rate.
// Backpressure: exercises ks_ready stalls, two-entry buffering and reseed flush.
module tb_lfsr_keystream;

    localparam logic [127:0] DEF_SEED = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         seed_load;
    logic [127:0] seed;
    logic         ks_valid;
    logic         ks_ready;
    logic [7:0]   ks_data;
    logic         busy;
    logic         zero_seed_err;
    logic         lockup;
    logic [127:0] state_out;

    logic         en_w;
    logic         seed_load_w;
    logic [127:0] seed_w;
    logic         ks_valid_w;
    logic         rdy_w;
    logic [7:0]   ks_data_w;
    logic         busy_w;
    logic         zero_seed_err_w;
    logic         lockup_w;
    logic [127:0] state_out_w;

    int           n_checks;
    int           n_err;
    logic [127:0] m_state;
    logic [7:0]   t1_words [4];

    lfsr_keystream #(.WARMUP_STEPS(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .seed_load     (seed_load),
        .seed          (seed),
        .ks_valid      (ks_valid),
        .ks_ready      (ks_ready),
        .ks_data       (ks_data),
        .busy          (busy),
        .zero_seed_err (zero_seed_err),
        .lockup        (lockup),
        .state_out     (state_out)
    );

    lfsr_keystream #(.WARMUP_STEPS(256)) dut_w (
        .clk           (clk),
        .rst           (rst),
        .enable        (en_w),
        .seed_load     (seed_load_w),
        .seed          (seed_w),
        .ks_valid      (ks_valid_w),
        .ks_ready      (rdy_w),
        .ks_data       (ks_data_w),
        .busy          (busy_w),
        .zero_seed_err (zero_seed_err_w),
        .lockup        (lockup_w),
        .state_out     (state_out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One LFSR shift: feedback is the parity of taps 127, 29, 27 and 2; zero result is replaced
    function automatic logic [127:0] mstep(input logic [127:0] s);
        logic         fb;
        logic [127:0] n;
        fb = s[127] ^ s[29] ^ s[27] ^ s[2];
        n  = (s >> 1) | ({127'd0, fb} << 127);
        if (n == 128'd0) n = DEF_SEED;
        return n;
    endfunction

    // Next keystream word: eight emitted bits, earliest in the LSB
    task automatic model_word(output logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            w[i]    = m_state[0];
            m_state = mstep(m_state);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        en_w        = 1'b0;
        seed_load   = 1'b0;
        ks_ready    = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        m_state = DEF_SEED;
    endtask

    // Accept n words (with whatever ks_ready currently is) and compare each with the model
    task automatic expect_words(input string tag, input int n, input int budget);
        int         got;
        logic [7:0] e;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (ks_valid && ks_ready) begin
                model_word(e);
                check(tag, 128'(ks_data), 128'(e));
                got++;
            end
            tick();
        end
        check({tag, "_count"}, 128'(got), 128'(n));
    endtask

    initial begin
        logic [127:0] s1;
        logic [127:0] s2;
        logic [127:0] exp_state;
        logic [7:0]   e;
        int           got;
        int           n;
        int           accepted;
        logic         saw_valid;

        n_checks     = 0;
        n_err        = 0;
        t1_words[0]  = 8'hEF;
        t1_words[1]  = 8'hCD;
        t1_words[2]  = 8'hAB;
        t1_words[3]  = 8'h89;
        seed         = '0;
        seed_load_w  = 1'b0;
        seed_w       = '0;
        rdy_w        = 1'b1;

        // Reset state
        rst = 1'b1; enable = 1'b0; en_w = 1'b0; seed_load = 1'b0; ks_ready = 1'b1;
        tick();
        tick();
        check("rst_valid",   128'(ks_valid), 128'(0));
        check("rst_data",    128'(ks_data), 128'(0));
        check("rst_busy",    128'(busy), 128'(0));
        check("rst_zerr",    128'(zero_seed_err), 128'(0));
        check("rst_lockup",  128'(lockup), 128'(0));
        check("rst_state",   state_out, DEF_SEED);
        check("rst_busy_w",  128'(busy_w), 128'(1));

        // Test 1: free-running stream from the default seed
        rst = 1'b0; enable = 1'b1; ks_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            repeat (7) tick();
            check("t1_gap_valid", 128'(ks_valid), 128'(0));
            tick();
            check("t1_valid", 128'(ks_valid), 128'(1));
            check("t1_data",  128'(ks_data), 128'(t1_words[w]));
            check("t1_busy",  128'(busy), 128'(0));
        end

        // Test 2: consumer stalls for 30 cycles
        do_reset();
        enable = 1'b1; ks_ready = 1'b0;
        exp_state = DEF_SEED;
        repeat (16) exp_state = mstep(exp_state);
        repeat (20) tick();
        check("t2_state_20", state_out, exp_state);
        repeat (10) tick();
        check("t2_state_30", state_out, exp_state);
        check("t2_valid",    128'(ks_valid), 128'(1));
        check("t2_held",     128'(ks_data), 128'(8'hEF));
        ks_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 3; c++) begin
            if (ks_valid && ks_ready) begin
                check("t2_word", 128'(ks_data), 128'(t1_words[got]));
                got++;
            end
            tick();
        end
        check("t2_count", 128'(got), 128'(3));

        // Test 3: zero seed substitution and sticky error
        enable = 1'b1; ks_ready = 1'b1;
        seed_load = 1'b1; seed = '0;
        tick();
        seed_load = 1'b0;
        check("t3_state", state_out, DEF_SEED);
        check("t3_zerr",  128'(zero_seed_err), 128'(1));
        check("t3_flush", 128'(ks_valid), 128'(0));
        m_state = DEF_SEED;
        expect_words("t3_word", 2, 60);
        check("t3_zerr_sticky", 128'(zero_seed_err), 128'(1));
        s1 = {$urandom, $urandom, $urandom, $urandom} | (128'd1 << 64);
        seed_load = 1'b1; seed = s1;
        tick();
        seed_load = 1'b0;
        check("t3_zerr_clr", 128'(zero_seed_err), 128'(0));
        check("t3_seed",     state_out, s1);

        // Randomized enable / ready traffic from the random seed
        m_state  = s1;
        accepted = 0;
        for (int c = 0; c < 800; c++) begin
            enable   = ($urandom_range(0, 3) != 0);
            ks_ready = $urandom_range(0, 1) == 1;
            if (ks_valid && ks_ready) begin
                model_word(e);
                check("rand_word", 128'(ks_data), 128'(e));
                accepted++;
            end
            tick();
        end
        check("rand_progress", 128'(accepted > 20), 128'(1));

        // Test 4: lock-up trap from seed 1
        enable = 1'b1; ks_ready = 1'b1;
        seed_load = 1'b1; seed = 128'd1;
        tick();
        seed_load = 1'b0;
        check("t4_state_load", state_out, 128'd1);
        check("t4_lock_pre",   128'(lockup), 128'(0));
        tick();
        check("t4_state_trap", state_out, DEF_SEED);
        check("t4_lock_pulse", 128'(lockup), 128'(1));
        tick();
        check("t4_lock_end",   128'(lockup), 128'(0));
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            if (ks_valid) begin
                check("t4_first_word", 128'(ks_data), 128'(8'hDF));
                got = 1;
            end else begin
                tick();
            end
        end
        check("t4_seen", 128'(got), 128'(1));

        // Test 6: reseed during a handshake while both buffer entries are full
        s1 = {$urandom, $urandom, $urandom, $urandom} | 128'd2;
        s2 = {$urandom, $urandom, $urandom, $urandom} | 128'd4;
        enable = 1'b1; ks_ready = 1'b0;
        seed_load = 1'b1; seed = s1;
        tick();
        seed_load = 1'b0;
        repeat (25) tick();
        exp_state = s1;
        repeat (16) exp_state = mstep(exp_state);
        check("t6_stalled", state_out, exp_state);
        check("t6_valid",   128'(ks_valid), 128'(1));
        seed_load = 1'b1; seed = s2; ks_ready = 1'b1;
        tick();
        seed_load = 1'b0;
        check("t6_flush", 128'(ks_valid), 128'(0));
        check("t6_state", state_out, s2);
        m_state = s2;
        expect_words("t6_word", 3, 100);

        // Test 5: 256-step warm-up, then a run with enable dropped for 13 cycles
        do_reset();
        check("t5_busy_rst", 128'(busy_w), 128'(1));
        en_w = 1'b1;
        n = 0;
        saw_valid = 1'b0;
        do begin
            tick();
            n++;
            if (ks_valid_w) saw_valid = 1'b1;
        end while (busy_w && n < 1000);
        check("t5_busy_len",  128'(n), 128'(256));
        check("t5_no_valid",  128'(saw_valid), 128'(0));
        repeat (7) tick();
        check("t5_valid_gap", 128'(ks_valid_w), 128'(0));
        tick();
        check("t5_valid",     128'(ks_valid_w), 128'(1));
        m_state = DEF_SEED;
        repeat (256) m_state = mstep(m_state);
        model_word(e);
        check("t5_first_word", 128'(ks_data_w), 128'(e));

        do_reset();
        en_w = 1'b1;
        repeat (100) tick();
        en_w = 1'b0;
        repeat (13) tick();
        check("t5_busy_mid", 128'(busy_w), 128'(1));
        en_w = 1'b1;
        n = 113;
        do begin
            tick();
            n++;
        end while (busy_w && n < 1000);
        check("t5_busy_ext", 128'(n), 128'(269));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
